// File: rtl/wb_trace_checker_pkg.sv
// Shared types for the trace checker: FSM states, error codes and
// the golden commit record layout.
package wb_trace_checker_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_ERROR = 2'd2,
        ST_DONE  = 2'd3
    } chk_state_e;

    typedef enum logic [1:0] {
        ERR_NONE      = 2'd0,
        ERR_MISMATCH  = 2'd1,
        ERR_UNDERFLOW = 2'd2,
        ERR_TIMEOUT   = 2'd3
    } err_code_e;

    localparam int GOLD_W    = 69;
    localparam int WDATA_LSB = 0;
    localparam int WNUM_LSB  = 32;
    localparam int PC_LSB    = 37;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  wnum;
        logic [31:0] wdata;
    } gold_t;

    function automatic logic [31:0] we_mask(input logic [3:0] we);
        return {{8{we[3]}}, {8{we[2]}}, {8{we[1]}}, {8{we[0]}}};
    endfunction

endpackage

// File: rtl/wb_trace_checker_fifo.sv
// Synchronous FIFO holding golden commit records; pointers wrap
// naturally because DEPTH is a power of two.
module wb_trace_checker_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 69
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_push,
    input  logic [W-1:0] i_data,
    input  logic         i_pop,
    output logic [W-1:0] o_head,
    output logic         o_full,
    output logic         o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [CW-1:0] r_cnt;
    logic          w_push;
    logic          w_pop;

    assign o_full  = (r_cnt == FULL_CNT);
    assign o_empty = (r_cnt == '0);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_head  = r_mem[r_rd];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) begin
                r_wr <= r_wr + 1'b1;
            end
            if (w_pop) begin
                r_rd <= r_rd + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_cnt <= r_cnt + 1'b1;
            end else if (w_pop && !w_push) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_trace_checker.sv
// Compares retired register writes from the CPU trace port against a
// buffered golden stream and latches the first failure.
module wb_trace_checker
    import wb_trace_checker_pkg::*;
#(
    parameter int          DEPTH   = 8,
    parameter int          TIMEOUT = 1024,
    parameter logic [31:0] END_PC  = 32'h1c000100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] debug_wb_pc,
    input  logic [3:0]  debug_wb_rf_we,
    input  logic [4:0]  debug_wb_rf_wnum,
    input  logic [31:0] debug_wb_rf_wdata,
    input  logic        gold_valid,
    output logic        gold_ready,
    input  logic [31:0] gold_pc,
    input  logic [4:0]  gold_wnum,
    input  logic [31:0] gold_wdata,
    output logic [1:0]  chk_state,
    output logic [1:0]  err_code,
    output logic [31:0] err_pc,
    output logic [31:0] err_exp_wdata,
    output logic [31:0] err_got_wdata,
    output logic [31:0] commit_cnt
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    chk_state_e  r_state;
    chk_state_e  w_next;
    err_code_e   r_err;
    logic [TW-1:0] r_tmo;
    logic [31:0] r_cnt;
    logic [31:0] r_err_pc;
    logic [31:0] r_err_exp;
    logic [31:0] r_err_got;

    gold_t       w_in;
    gold_t       w_head;
    logic [GOLD_W-1:0] w_head_bits;
    logic        w_full;
    logic        w_empty;
    logic        w_run;
    logic        w_commit;
    logic        w_fields_eq;
    logic        w_match;
    logic        w_mismatch;
    logic        w_underflow;
    logic        w_tmo_hit;
    logic        w_push;
    logic [31:0] w_mask;

    assign w_in   = '{pc: gold_pc, wnum: gold_wnum, wdata: gold_wdata};
    assign w_head = gold_t'(w_head_bits);
    assign w_push = gold_valid && gold_ready;
    assign w_run  = (r_state == ST_RUN);
    assign w_mask = we_mask(debug_wb_rf_we);

    assign w_commit = w_run && (debug_wb_rf_we != '0)
                      && (debug_wb_rf_wnum != '0);

    // Bytes the CPU did not write are don't-care in the comparison.
    assign w_fields_eq = (w_head.pc == debug_wb_pc)
        && (w_head.wnum == debug_wb_rf_wnum)
        && (((w_head.wdata ^ debug_wb_rf_wdata) & w_mask) == '0);

    assign w_match     = w_commit && !w_empty && w_fields_eq;
    assign w_mismatch  = w_commit && !w_empty && !w_fields_eq;
    assign w_underflow = w_commit && w_empty;
    assign w_tmo_hit   = w_run && !w_commit && (r_tmo == TMO_LAST);

    wb_trace_checker_fifo #(
        .DEPTH (DEPTH),
        .W     (GOLD_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (w_in),
        .i_pop   (w_match),
        .o_head  (w_head_bits),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE: w_next = ST_RUN;
            ST_RUN: begin
                if (w_underflow || w_mismatch || w_tmo_hit) begin
                    w_next = ST_ERROR;
                end else if (w_match && (debug_wb_pc == END_PC)) begin
                    w_next = ST_DONE;
                end
            end
            ST_ERROR: w_next = ST_ERROR;
            ST_DONE:  w_next = ST_DONE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        gold_ready = w_run && !w_full;
        chk_state  = r_state;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tmo     <= '0;
            r_cnt     <= '0;
            r_err     <= ERR_NONE;
            r_err_pc  <= '0;
            r_err_exp <= '0;
            r_err_got <= '0;
        end else if (w_run) begin
            if (w_match) begin
                r_cnt <= r_cnt + 32'd1;
            end
            if (w_commit) begin
                r_tmo <= '0;
            end else if (!w_tmo_hit) begin
                r_tmo <= r_tmo + 1'b1;
            end
            // Only reachable from RUN, so this fires once per run.
            if (w_underflow) begin
                r_err     <= ERR_UNDERFLOW;
                r_err_pc  <= debug_wb_pc;
                r_err_exp <= '0;
                r_err_got <= debug_wb_rf_wdata;
            end else if (w_mismatch) begin
                r_err     <= ERR_MISMATCH;
                r_err_pc  <= debug_wb_pc;
                r_err_exp <= w_head.wdata;
                r_err_got <= debug_wb_rf_wdata;
            end else if (w_tmo_hit) begin
                r_err     <= ERR_TIMEOUT;
                r_err_pc  <= '0;
                r_err_exp <= '0;
                r_err_got <= '0;
            end
        end
    end

    assign err_code      = r_err;
    assign err_pc        = r_err_pc;
    assign err_exp_wdata = r_err_exp;
    assign err_got_wdata = r_err_got;
    assign commit_cnt    = r_cnt;

endmodule
